// File: rtl/irrigation_pkg.sv
// ----------------------------------------------------------------------------
// irrigation_pkg : shared state encoding and default timing for the scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package irrigation_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DRIP     = 3'd1;
   localparam logic [2:0] ST_SPRINKLE = 3'd2;
   localparam logic [2:0] ST_COOLDOWN = 3'd3;
   localparam logic [2:0] ST_FAULT    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_DRIP     = ST_DRIP,
      S_SPRINKLE = ST_SPRINKLE,
      S_COOLDOWN = ST_COOLDOWN,
      S_FAULT    = ST_FAULT
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_MIN_ON_CYCLES   = 16;
   localparam int DEF_MAX_ON_CYCLES   = 200;
   localparam int DEF_COOLDOWN_CYCLES = 8;
   localparam int DEF_COUNT_WIDTH     = 8;

endpackage

`default_nettype wire

// File: rtl/sensor_debouncer.sv
// ----------------------------------------------------------------------------
// sensor_debouncer : 2-flop synchroniser plus stable-run filter for one bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sensor_debouncer
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic filt_out
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // Any sample that agrees with the filtered value restarts the run.
   always_comb begin
      sync_d = {sync_q[0], raw_in};
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == C_LAST) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt_out = filt_q;

endmodule

`default_nettype wire

// File: rtl/irrigation_scheduler.sv
// ----------------------------------------------------------------------------
// irrigation_scheduler : debounced sensors -> drip/sprinkle/cooldown/fault FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
   parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
   input  logic clock,
   input  logic reset,
   input  logic system_enable,
   input  logic humidity_low,
   input  logic humidity_critical,
   input  logic tank_empty,
   output logic irrigation_on,
   output logic splinker_on,
   output logic dripper_on,
   output logic alarm,
   output logic busy
);

   localparam logic [COUNT_WIDTH-1:0] C_MIN_LAST = COUNT_WIDTH'(MIN_ON_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] C_MAX_LAST = COUNT_WIDTH'(MAX_ON_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] C_CD_LAST  = COUNT_WIDTH'(COOLDOWN_CYCLES - 1);

   logic [2:0] raw_vec;
   logic [2:0] filt_vec;
   logic       low_f, critical_f, tank_f;

   assign raw_vec    = {tank_empty, humidity_critical, humidity_low};
   assign low_f      = filt_vec[0];
   assign critical_f = filt_vec[1];
   assign tank_f     = filt_vec[2];

   for (genvar gi = 0; gi < 3; gi++) begin : g_sensor
      sensor_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock   (clock),
         .reset   (reset),
         .raw_in  (raw_vec[gi]),
         .filt_out(filt_vec[gi])
      );
   end

   // Enable is a user level switch; synchronised only, not debounced.
   logic [1:0] en_sync_q, en_sync_d;
   logic       enable_s;
   assign enable_s = en_sync_q[1];

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic irrigation_q, irrigation_d;
   logic splinker_q, splinker_d;
   logic dripper_q, dripper_d;
   logic alarm_q, alarm_d;
   logic busy_q, busy_d;

   always_comb begin
      en_sync_d = {en_sync_q[0], system_enable};
      state_d   = state_q;
      case (state_q)
         S_IDLE: begin
            if (tank_f)                  state_d = S_FAULT;
            else if (enable_s) begin
               if (critical_f)           state_d = S_SPRINKLE;
               else if (low_f)           state_d = S_DRIP;
            end
         end
         S_DRIP: begin
            if (tank_f)                  state_d = S_FAULT;
            else if (!enable_s)          state_d = S_COOLDOWN;
            else if (count_q == C_MAX_LAST) state_d = S_COOLDOWN;
            else if (critical_f)         state_d = S_SPRINKLE;
            else if (count_q >= C_MIN_LAST && !low_f) state_d = S_COOLDOWN;
         end
         S_SPRINKLE: begin
            if (tank_f)                  state_d = S_FAULT;
            else if (!enable_s)          state_d = S_COOLDOWN;
            else if (count_q == C_MAX_LAST) state_d = S_COOLDOWN;
            else if (count_q >= C_MIN_LAST && !critical_f)
               state_d = low_f ? S_DRIP : S_COOLDOWN;
         end
         S_COOLDOWN: begin
            if (tank_f)                  state_d = S_FAULT;
            else if (count_q == C_CD_LAST) state_d = S_IDLE;
         end
         S_FAULT: begin
            if (!tank_f)                 state_d = S_COOLDOWN;
         end
         default:                        state_d = S_IDLE;
      endcase

      // Counter restarts on any transition, including a drip/sprinkle swap.
      if (state_d != state_q)     count_d = '0;
      else if (&count_q)          count_d = count_q;
      else                        count_d = count_q + COUNT_WIDTH'(1);

      dripper_d    = (state_d == S_DRIP);
      splinker_d   = (state_d == S_SPRINKLE);
      irrigation_d = dripper_d | splinker_d;
      alarm_d      = (state_d == S_FAULT);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         en_sync_q    <= '0;
         state_q      <= S_IDLE;
         count_q      <= '0;
         irrigation_q <= 1'b0;
         splinker_q   <= 1'b0;
         dripper_q    <= 1'b0;
         alarm_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         en_sync_q    <= en_sync_d;
         state_q      <= state_d;
         count_q      <= count_d;
         irrigation_q <= irrigation_d;
         splinker_q   <= splinker_d;
         dripper_q    <= dripper_d;
         alarm_q      <= alarm_d;
         busy_q       <= busy_d;
      end
   end

   assign irrigation_on = irrigation_q;
   assign splinker_on   = splinker_q;
   assign dripper_on    = dripper_q;
   assign alarm         = alarm_q;
   assign busy          = busy_q;

endmodule

`default_nettype wire
